// File: rtl/laundry_load_sequencer.sv
// laundry_load_sequencer
//   Queues laundry load requests in a small FIFO and walks each load through
//   wash, dry and finish phases on an external machine, reporting one
//   completion pulse per load. Every phase is guarded by a timer; a phase that
//   never sees its done input ends the load with cmp_err=1.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_id    load request offer; accepted when req_ready=1
//   req_ready           queue not full
//   washer_door         high throughout the wash phase
//   dryer_door          high throughout the dry phase
//   clothes             load present in the machine (wash, dry or finish)
//   washer_done         machine: wash finished (only looked at in wash)
//   dryer_done          machine: dry finished (only looked at in dry)
//   done                machine: cycle finished (only looked at in finish)
//   cmp_valid           one-cycle completion pulse
//   cmp_id/cmp_err      completed load ID and timeout flag; held between pulses
//   busy                FSM not idle
//   loads_done          wrapping count of error-free completions
module laundry_load_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [ID_W-1:0] req_id,
  output logic            req_ready,
  output logic            washer_door,
  output logic            dryer_door,
  output logic            clothes,
  input  logic            washer_done,
  input  logic            dryer_done,
  input  logic            done,
  output logic            cmp_valid,
  output logic [ID_W-1:0] cmp_id,
  output logic            cmp_err,
  output logic            busy,
  output logic [7:0]      loads_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WASH, DRY, FIN, CMPL} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [ID_W-1:0] id_q;
  logic            err_q;

  // ---------------------------------------------------------------- FIFO
  logic [ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, empty;

  assign empty     = (count == '0);
  assign req_ready = (count != FULL_CNT);
  assign push      = req_valid && req_ready;
  // Pop decision uses the registered count, so an entry written this edge is
  // only seen by the FSM on the following cycle.
  assign pop       = (state == IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  // Outputs are registered: each transition sets the output values that
  // belong to the destination state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      washer_door <= 1'b0;
      dryer_door  <= 1'b0;
      clothes     <= 1'b0;
      busy        <= 1'b0;
      cmp_valid   <= 1'b0;
      cmp_id      <= '0;
      cmp_err     <= 1'b0;
      loads_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            id_q        <= mem[rd_ptr];
            state       <= WASH;
            timer       <= '0;
            washer_door <= 1'b1;
            clothes     <= 1'b1;
            busy        <= 1'b1;
          end
        end
        WASH: begin
          // done is honoured even on the final timer cycle
          if (washer_done) begin
            state       <= DRY;
            timer       <= '0;
            washer_door <= 1'b0;
            dryer_door  <= 1'b1;
          end else if (timer == T_LAST) begin
            state       <= CMPL;
            err_q       <= 1'b1;
            washer_door <= 1'b0;
            clothes     <= 1'b0;
            cmp_valid   <= 1'b1;
            cmp_id      <= id_q;
            cmp_err     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DRY: begin
          if (dryer_done) begin
            state      <= FIN;
            timer      <= '0;
            dryer_door <= 1'b0;
          end else if (timer == T_LAST) begin
            state      <= CMPL;
            err_q      <= 1'b1;
            dryer_door <= 1'b0;
            clothes    <= 1'b0;
            cmp_valid  <= 1'b1;
            cmp_id     <= id_q;
            cmp_err    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FIN: begin
          if (done || timer == T_LAST) begin
            state     <= CMPL;
            err_q     <= !done;
            clothes   <= 1'b0;
            cmp_valid <= 1'b1;
            cmp_id    <= id_q;
            cmp_err   <= !done;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CMPL: begin
          state     <= IDLE;
          cmp_valid <= 1'b0;
          busy      <= 1'b0;
          timer     <= '0;
          if (!err_q) loads_done <= loads_done + 8'd1;
        end
        default: begin
          state       <= IDLE;
          washer_door <= 1'b0;
          dryer_door  <= 1'b0;
          clothes     <= 1'b0;
          busy        <= 1'b0;
          cmp_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laundry_load_sequencer.sv
// Self-checking bench for laundry_load_sequencer. A small machine model
// answers each phase a programmable number of cycles after entry (0 = never).
// Expected completions are queued on acceptance and matched on cmp_valid.
module tb_laundry_load_sequencer;
  localparam int DEPTH = 4, ID_W = 4, TIMEOUT = 16;

  logic            clk = 1'b0, rst = 1'b0;
  logic            req_valid = 1'b0;
  logic [ID_W-1:0] req_id = '0;
  logic            req_ready, washer_door, dryer_door, clothes;
  logic            washer_done = 1'b0, dryer_done = 1'b0, done = 1'b0;
  logic            cmp_valid, cmp_err, busy;
  logic [ID_W-1:0] cmp_id;
  logic [7:0]      loads_done;

  laundry_load_sequencer #(.DEPTH(DEPTH), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_id(req_id),
    .req_ready(req_ready), .washer_door(washer_door), .dryer_door(dryer_door),
    .clothes(clothes), .washer_done(washer_done), .dryer_done(dryer_done),
    .done(done), .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_err(cmp_err),
    .busy(busy), .loads_done(loads_done)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic            err;
    int              lat;   // expected cycles from wash entry to cmp_valid, 0 = unchecked
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0, n_fail = 0;
  int         cyc = 0;
  int         wash_lat = 5, dry_lat = 5, fin_lat = 5;
  logic [7:0] exp_loads = '0;
  int         wash_start = 0;
  logic       wd_prev = 1'b0, saw_w = 1'b0, saw_wd = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Machine model: done input pulses on cycle lat-1 of the phase.
  initial begin
    int wcnt, dcnt, fcnt;
    wcnt = 0; dcnt = 0; fcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wcnt = 0; dcnt = 0; fcnt = 0;
        washer_done = 1'b0; dryer_done = 1'b0; done = 1'b0;
      end else begin
        wcnt = washer_door ? wcnt + 1 : 0;
        dcnt = dryer_door  ? dcnt + 1 : 0;
        fcnt = (clothes && !washer_door && !dryer_door) ? fcnt + 1 : 0;
        washer_done = (wash_lat != 0) && (wcnt == wash_lat);
        dryer_done  = (dry_lat  != 0) && (dcnt == dry_lat);
        done        = (fin_lat  != 0) && (fcnt == fin_lat);
      end
    end
  end

  // Output monitor and scoreboard consumer
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("door_excl", 32'(washer_door & dryer_door), 0);
      chk("clothes_door", 32'((washer_door | dryer_door) & ~clothes), 0);
      chk("busy_clothes", 32'(clothes & ~busy), 0);
      if (washer_door && !wd_prev) wash_start = cyc;
      wd_prev = washer_door;
      if (washer_door) saw_w = 1'b1;
      if (dryer_door && saw_w) saw_wd = 1'b1;
      if (cmp_valid) begin
        if (sb.size() == 0) chk("cmp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("cmp_id", 32'(cmp_id), 32'(e.id));
          chk("cmp_err", 32'(cmp_err), 32'(e.err));
          if (e.lat != 0) chk("timeout_latency", cyc - wash_start, e.lat);
          if (!e.err) exp_loads++;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input int id, input logic err, input int lat);
    exp_t e;
    int n = 0;
    req_valid = 1'b1;
    req_id    = ID_W'(id);
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("send_stall", 0, 1);
    else begin
      e.id = ID_W'(id); e.err = err; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size() == 0 && !busy), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    #2 rst = 1'b1;
    #2;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_wdoor", 32'(washer_door), 0);
    chk("rst_ddoor", 32'(dryer_door), 0);
    chk("rst_clothes", 32'(clothes), 0);
    chk("rst_cmp_valid", 32'(cmp_valid), 0);
    chk("rst_cmp_id", 32'(cmp_id), 0);
    chk("rst_cmp_err", 32'(cmp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_loads", 32'(loads_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single load, normal sequence
    saw_w = 1'b0; saw_wd = 1'b0;
    send(3, 1'b0, 0);
    wait_idle();
    chk("wash_then_dry", 32'(saw_wd), 1);
    chk("loads_single", 32'(loads_done), 1);

    // fill the queue while stalled in WASH
    wash_lat = 12;
    send(10, 1'b0, 0);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    chk("busy_started", 32'(busy), 1);
    for (int i = 1; i <= 4; i++) send(i, 1'b0, 0);
    chk("full_ready", 32'(req_ready), 0);
    send(5, 1'b0, 0);
    wait_idle();
    chk("loads_fifo", 32'(loads_done), 32'(exp_loads));
    chk("loads_fifo_abs", 32'(loads_done), 7);

    // wash timeout, then the next load runs normally
    wash_lat = 0;
    send(7, 1'b1, TIMEOUT);
    send(8, 1'b0, 0);
    n = 0;
    while (!cmp_valid && n < 200) begin @(negedge clk); n++; end
    chk("to_seen", 32'(cmp_valid), 1);
    chk("to_loads_unchanged", 32'(loads_done), 7);
    wash_lat = 5;
    wait_idle();
    chk("loads_after_to", 32'(loads_done), 8);

    // washer_done on the last permitted cycle
    wash_lat = TIMEOUT;
    send(9, 1'b0, 0);
    wait_idle();
    wash_lat = 3;
    // dry timeout
    dry_lat = 0;
    send(11, 1'b1, 0);
    wait_idle();
    chk("loads_edge", 32'(loads_done), 9);
    chk("loads_edge_model", 32'(loads_done), 32'(exp_loads));

    // reset during DRY with two loads queued
    send(12, 1'b0, 0);
    send(13, 1'b0, 0);
    send(14, 1'b0, 0);
    n = 0;
    while (!dryer_door && n < 50) begin @(negedge clk); n++; end
    chk("in_dry", 32'(dryer_door), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 1);
    chk("mid_rst_ddoor", 32'(dryer_door), 0);
    chk("mid_rst_clothes", 32'(clothes), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cmp_valid", 32'(cmp_valid), 0);
    chk("mid_rst_cmp_id", 32'(cmp_id), 0);
    chk("mid_rst_loads", 32'(loads_done), 0);
    sb.delete();
    exp_loads = '0;
    dry_lat = 5;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_ready", 32'(req_ready), 1);

    // 256 error-free loads wrap the counter
    wash_lat = 1; dry_lat = 1; fin_lat = 1;
    for (int i = 0; i < 256; i++) send(i, 1'b0, 0);
    wait_idle();
    chk("loads_wrap", 32'(loads_done), 0);
    chk("loads_wrap_model", 32'(loads_done), 32'(exp_loads));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
